// File: rtl/linreg_pkg.sv
// Shared constants and state encoding for the linear price model blocks.
// Used by both the forward (size->price) and inverse (price->size) evaluators.
package linreg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [15:0] COEF_DEF      = 16'd10000;
   localparam logic [31:0] INTERCEPT_DEF = 32'd10000;

   localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_step_seize.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step_seize (
   input  logic [16:0] prem,
   input  logic        bit_in,
   input  logic [15:0] divisor,
   output logic [16:0] next_prem,
   output logic        q_bit
);

   logic [17:0] shifted;
   logic [17:0] diff;
   logic        fits;

   // Trial subtraction; the partial remainder stays below the divisor, so
   // the shifted value never needs more than 17 significant bits.
   always_comb begin
      shifted   = {prem, bit_in};
      diff      = shifted - {2'b00, divisor};
      fits      = (shifted >= {2'b00, divisor});
      q_bit     = fits;
      next_prem = 17'(fits ? diff : shifted);
   end

endmodule

// File: rtl/linear_regression_inverse.sv
// Inverse evaluator for price = COEF*size + INTERCEPT.
// Recovers size = (price - INTERCEPT) / COEF with a bit-serial restoring
// divider behind a start/done handshake.
// Optional build macro LINREG_INV_ROUND_EN: round the quotient to nearest
// (halves up); rem still reports the truncating remainder.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; results from last operation held
// SUB     | subtract INTERCEPT, detect underflow, load the divider
// DIV     | 32 restoring steps, MSB first, one per cycle
// DONE    | results valid, done pulses for one cycle
module linear_regression_inverse
   import linreg_pkg::*;
#(
   parameter logic [15:0] COEF      = COEF_DEF,
   parameter logic [31:0] INTERCEPT = INTERCEPT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] price,
   output logic        busy,
   output logic        done,
   output logic [15:0] size,
   output logic [15:0] rem,
   output logic        underflow,
   output logic        overflow
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] price_r;
   logic [31:0] dvd_q;
   logic [16:0] prem;
   logic [4:0]  cnt;
   logic [32:0] d33;
   logic        last_step;

   logic [16:0] step_prem;
   logic        step_q;

   logic [31:0] q_fin;
   logic [32:0] q_adj;
   logic        ovf_fin;
   logic [15:0] size_fin;

   assign d33       = {1'b0, price_r} - {1'b0, INTERCEPT};
   assign last_step = (cnt == 5'(DIV_STEPS - 1));
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   // The dividend register doubles as the quotient register: dividend bits
   // leave at the top while quotient bits enter at the bottom.
   div_step_seize u_step (
      .prem      (prem),
      .bit_in    (dvd_q[31]),
      .divisor   (COEF),
      .next_prem (step_prem),
      .q_bit     (step_q)
   );

   // Final quotient, optional rounding and saturation, taken on the last step.
   always_comb begin
      q_fin = {dvd_q[30:0], step_q};
`ifdef LINREG_INV_ROUND_EN
      q_adj = {1'b0, q_fin} + {32'd0, ({step_prem, 1'b0} >= {2'b00, COEF})};
`else
      q_adj = {1'b0, q_fin};
`endif
      ovf_fin  = |q_adj[32:16];
      size_fin = ovf_fin ? 16'hFFFF : q_adj[15:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_SUB;
         ST_SUB:  state_nxt = d33[32] ? ST_DONE : ST_DIV;
         ST_DIV:  if (last_step) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and result registers; results are only touched from SUB onward
   // so they hold across IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         price_r   <= '0;
         dvd_q     <= '0;
         prem      <= '0;
         cnt       <= '0;
         size      <= '0;
         rem       <= '0;
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) price_r <= price;
            ST_SUB: begin
               size      <= '0;
               rem       <= '0;
               overflow  <= 1'b0;
               underflow <= d33[32];
               dvd_q     <= d33[31:0];
               prem      <= '0;
               cnt       <= '0;
            end
            ST_DIV: begin
               prem  <= step_prem;
               dvd_q <= {dvd_q[30:0], step_q};
               cnt   <= cnt + 5'd1;
               if (last_step) begin
                  size     <= size_fin;
                  rem      <= step_prem[15:0];
                  overflow <= ovf_fin;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
